// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the gated frequency counter and its display path.
package freq_counter_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Largest value representable with n decimal digits (10^n - 1)
    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/freq_counter_gated_seg7.sv
// Single-digit BCD to 7-segment decoder; non-decimal codes show dark.
module seg7_decode
    import freq_counter_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    // Pattern lookup for one digit
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/freq_counter_gated.sv
// Gated frequency counter: counts sigin rising edges per GATE_CYCLES window,
// then converts the result to BCD / 7-segment with a serial double-dabble.
//
// state | meaning
// IDLE  | waiting for a window capture
// SHIFT | double-dabble, one bit per cycle, COUNT_W cycles
// DONE  | publish result (unless hold) and pulse valid
module freq_counter_gated
    import freq_counter_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int NUM_DIGITS  = 5
) (
    input  logic                        clck,
    input  logic                        reset,
    input  logic                        sigin,
    input  logic                        enable,
    input  logic                        hold,
    output logic [COUNT_W-1:0]          number,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd,
    output logic [SEG_W*NUM_DIGITS-1:0] segment,
    output logic                        overflow,
    output logic                        valid
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SCNT_W = $clog2(COUNT_W + 1);
    localparam int DIG_W  = BCD_W * NUM_DIGITS;
    localparam int SEGS_W = SEG_W * NUM_DIGITS;
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [63:0]        DEC_MAX   = pow10_minus1(NUM_DIGITS);

    // The converter must be back in IDLE before the next window closes
    if (GATE_CYCLES < COUNT_W + 4) begin : g_gate_check
        $error("freq_counter_gated: GATE_CYCLES must be >= COUNT_W+4");
    end

    logic [2:0]         sync_q;
    logic               sig_rise;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic               at_max, terminal, cap_sat;
    logic [COUNT_W-1:0] cap_value;

    conv_state_e        state_q, state_d;
    logic [COUNT_W-1:0] bin_q, bin_d;
    logic [COUNT_W-1:0] res_q, res_d;
    logic [DIG_W-1:0]   dig_q, dig_d, adj;
    logic [SCNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic               ovf_q, ovf_d;
    logic [SEGS_W-1:0]  seg_dec;

    logic [COUNT_W-1:0] number_q, number_d;
    logic [DIG_W-1:0]   bcd_q, bcd_d;
    logic [SEGS_W-1:0]  segment_q, segment_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;

    // sync_q[0..2] = s1..s3; rising edge seen between s2 and s3
    assign sig_rise = sync_q[1] & ~sync_q[2];

    // Window timing and edge accumulation; the terminal cycle includes its own edge
    always_comb begin
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        terminal   = 1'b0;
        at_max     = (edge_cnt_q == CNT_MAX);
        cap_value  = (sig_rise && !at_max) ? edge_cnt_q + COUNT_W'(1) : edge_cnt_q;
        cap_sat    = sat_q | (sig_rise & at_max);
        if (!enable) begin
            gate_d     = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else if (gate_q == GATE_LAST) begin
            terminal   = 1'b1;
            gate_d     = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else begin
            gate_d     = gate_q + GATE_W'(1);
            edge_cnt_d = cap_value;
            sat_d      = cap_sat;
        end
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q[BCD_W*i +: BCD_W] >= 4'd5) begin
                adj[BCD_W*i +: BCD_W] = dig_q[BCD_W*i +: BCD_W] + 4'd3;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        seg7_decode u_seg (
            .bcd_i (dig_q[BCD_W*g +: BCD_W]),
            .seg_o (seg_dec[SEG_W*g +: SEG_W])
        );
    end

    // Conversion FSM next-state and output register updates
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        res_d       = res_q;
        dig_d       = dig_q;
        shift_cnt_d = shift_cnt_q;
        ovf_d       = ovf_q;
        number_d    = number_q;
        bcd_d       = bcd_q;
        segment_d   = segment_q;
        overflow_d  = overflow_q;
        valid_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (terminal) begin
                    state_d     = SHIFT;
                    bin_d       = cap_value;
                    res_d       = cap_value;
                    dig_d       = '0;
                    shift_cnt_d = SCNT_W'(COUNT_W - 1);
                    ovf_d       = cap_sat | (64'(cap_value) > DEC_MAX);
                end
            end
            SHIFT: begin
                {dig_d, bin_d} = {adj, bin_q} << 1;
                if (shift_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    shift_cnt_d = shift_cnt_q - SCNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!hold) begin
                    number_d   = res_q;
                    bcd_d      = dig_q;
                    segment_d  = seg_dec;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers with synchronous reset
    always_ff @(posedge clck) begin
        if (reset) begin
            sync_q      <= '0;
            gate_q      <= '0;
            edge_cnt_q  <= '0;
            sat_q       <= 1'b0;
            state_q     <= IDLE;
            bin_q       <= '0;
            res_q       <= '0;
            dig_q       <= '0;
            shift_cnt_q <= '0;
            ovf_q       <= 1'b0;
            number_q    <= '0;
            bcd_q       <= '0;
            segment_q   <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], sigin};
            gate_q      <= gate_d;
            edge_cnt_q  <= edge_cnt_d;
            sat_q       <= sat_d;
            state_q     <= state_d;
            bin_q       <= bin_d;
            res_q       <= res_d;
            dig_q       <= dig_d;
            shift_cnt_q <= shift_cnt_d;
            ovf_q       <= ovf_d;
            number_q    <= number_d;
            bcd_q       <= bcd_d;
            segment_q   <= segment_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
        end
    end

    assign number   = number_q;
    assign bcd      = bcd_q;
    assign segment  = segment_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_freq_counter_gated.sv
// Directed bench for freq_counter_gated: three parameterisations share one clock.
// A: COUNT_W=16 GATE=100 5 digits; B: COUNT_W=4 GATE=64 5 digits; C: COUNT_W=8 GATE=100 1 digit.
module tb_freq_counter_gated;

    localparam logic [6:0] S0 = 7'h3F;
    localparam logic [6:0] S1 = 7'h06;
    localparam logic [6:0] S2 = 7'h5B;
    localparam logic [6:0] S4 = 7'h66;
    localparam logic [6:0] S5 = 7'h6D;

    logic clk;
    int tests_run;
    int tests_failed;

    logic rst_a, sig_a, en_a, hold_a, ovf_a, val_a;
    logic [15:0] num_a;
    logic [19:0] bcd_a;
    logic [34:0] seg_a;
    int half_a, cnt_a;

    logic rst_b, sig_b, en_b, hold_b, ovf_b, val_b;
    logic [3:0]  num_b;
    logic [19:0] bcd_b;
    logic [34:0] seg_b;
    int half_b, cnt_b;

    logic rst_c, sig_c, en_c, hold_c, ovf_c, val_c;
    logic [7:0] num_c;
    logic [3:0] bcd_c;
    logic [6:0] seg_c;
    int half_c, cnt_c;

    freq_counter_gated #(.COUNT_W(16), .GATE_CYCLES(100), .NUM_DIGITS(5)) dut_a (
        .clck(clk), .reset(rst_a), .sigin(sig_a), .enable(en_a), .hold(hold_a),
        .number(num_a), .bcd(bcd_a), .segment(seg_a), .overflow(ovf_a), .valid(val_a));

    freq_counter_gated #(.COUNT_W(4), .GATE_CYCLES(64), .NUM_DIGITS(5)) dut_b (
        .clck(clk), .reset(rst_b), .sigin(sig_b), .enable(en_b), .hold(hold_b),
        .number(num_b), .bcd(bcd_b), .segment(seg_b), .overflow(ovf_b), .valid(val_b));

    freq_counter_gated #(.COUNT_W(8), .GATE_CYCLES(100), .NUM_DIGITS(1)) dut_c (
        .clck(clk), .reset(rst_c), .sigin(sig_c), .enable(en_c), .hold(hold_c),
        .number(num_c), .bcd(bcd_c), .segment(seg_c), .overflow(ovf_c), .valid(val_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square-wave generators: toggle every half_x clocks, stopped while half_x == 0
    initial forever begin
        @(negedge clk); #1;
        if (half_a != 0) begin
            if (cnt_a >= half_a - 1) begin sig_a = ~sig_a; cnt_a = 0; end
            else cnt_a++;
        end
    end
    initial forever begin
        @(negedge clk); #1;
        if (half_b != 0) begin
            if (cnt_b >= half_b - 1) begin sig_b = ~sig_b; cnt_b = 0; end
            else cnt_b++;
        end
    end
    initial forever begin
        @(negedge clk); #1;
        if (half_c != 0) begin
            if (cnt_c >= half_c - 1) begin sig_c = ~sig_c; cnt_c = 0; end
            else cnt_c++;
        end
    end

    // Wait for a valid pulse on the selected DUT; n = posedges until it is seen
    task automatic wait_valid(input int sel, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(posedge clk); #1;
            n++;
            case (sel)
                0:       seen = val_a;
                1:       seen = val_b;
                default: seen = val_c;
            endcase
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout_dut%0d: no valid after %0d cycles, required one", sel, budget);
        end
    endtask

    task automatic count_valid_a(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (val_a) cnt++;
        end
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        en_a = 1; en_b = 0; en_c = 0;
        hold_a = 0; hold_b = 0; hold_c = 0;
        sig_a = 0; sig_b = 0; sig_c = 0;
        half_a = 0; half_b = 0; half_c = 0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (num_a !== 16'd0) begin tests_failed++; $display("FAIL reset_number: got %0d need 0", num_a); end
        tests_run++;
        if (bcd_a !== 20'h0) begin tests_failed++; $display("FAIL reset_bcd: got %h need 0", bcd_a); end
        tests_run++;
        if (seg_a !== 35'h0) begin tests_failed++; $display("FAIL reset_segment: got %h need 0", seg_a); end
        tests_run++;
        if (ovf_a !== 1'b0 || val_a !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: ovf=%b valid=%b need 0 0", ovf_a, val_a); end
        tests_run++;
        if (seg_b !== 35'h0 || seg_c !== 7'h0) begin tests_failed++; $display("FAIL reset_segment_bc: got %h %h need 0 0", seg_b, seg_c); end
    endtask

    task automatic test_basic();
        int n;
        @(negedge clk);
        rst_a = 0; half_a = 5;
        wait_valid(0, 300, n);
        // terminal is window cycle GATE-1 = 99, valid COUNT_W+2 = 18 later
        tests_run++;
        if (n != 117) begin tests_failed++; $display("FAIL basic_latency: got %0d cycles need 117", n); end
        tests_run++;
        if (num_a !== 16'd10) begin tests_failed++; $display("FAIL basic_number: got %0d need 10", num_a); end
        tests_run++;
        if (bcd_a !== 20'h00010) begin tests_failed++; $display("FAIL basic_bcd: got %h need 00010", bcd_a); end
        tests_run++;
        if (seg_a !== {S0, S0, S0, S1, S0}) begin tests_failed++; $display("FAIL basic_segment: got %h need %h", seg_a, {S0, S0, S0, S1, S0}); end
        tests_run++;
        if (ovf_a !== 1'b0) begin tests_failed++; $display("FAIL basic_overflow: got %b need 0", ovf_a); end
        @(posedge clk); #1;
        tests_run++;
        if (val_a !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_width: got %b need 0", val_a); end
        wait_valid(0, 200, n);
        tests_run++;
        if (n != 99) begin tests_failed++; $display("FAIL basic_period: got %0d cycles need 99", n); end
        tests_run++;
        if (num_a !== 16'd10) begin tests_failed++; $display("FAIL basic_number2: got %0d need 10", num_a); end
    endtask

    task automatic test_enable();
        int n;
        int c;
        @(negedge clk);
        en_a = 0; half_a = 2;
        count_valid_a(300, c);
        tests_run++;
        if (c != 0) begin tests_failed++; $display("FAIL enable_off_valid: got %0d pulses need 0", c); end
        tests_run++;
        if (num_a !== 16'd10 || bcd_a !== 20'h00010) begin tests_failed++; $display("FAIL enable_off_hold: got %0d/%h need 10/00010", num_a, bcd_a); end
        @(negedge clk);
        en_a = 1;
        wait_valid(0, 300, n);
        tests_run++;
        if (n != 117) begin tests_failed++; $display("FAIL enable_latency: got %0d cycles need 117", n); end
        tests_run++;
        if (num_a !== 16'd25) begin tests_failed++; $display("FAIL enable_number: got %0d need 25", num_a); end
        tests_run++;
        if (bcd_a !== 20'h00025 || seg_a !== {S0, S0, S0, S2, S5}) begin tests_failed++; $display("FAIL enable_display: got %h/%h need 00025/%h", bcd_a, seg_a, {S0, S0, S0, S2, S5}); end
    endtask

    task automatic test_hold();
        int n;
        int c;
        @(negedge clk);
        hold_a = 1; half_a = 10;
        count_valid_a(250, c);
        tests_run++;
        if (c != 0) begin tests_failed++; $display("FAIL hold_valid: got %0d pulses need 0", c); end
        tests_run++;
        if (num_a !== 16'd25 || bcd_a !== 20'h00025) begin tests_failed++; $display("FAIL hold_frozen: got %0d/%h need 25/00025", num_a, bcd_a); end
        @(negedge clk);
        hold_a = 0;
        wait_valid(0, 150, n);
        tests_run++;
        if (num_a !== 16'd5 || ovf_a !== 1'b0) begin tests_failed++; $display("FAIL hold_release_number: got %0d ovf=%b need 5 ovf=0", num_a, ovf_a); end
        tests_run++;
        if (bcd_a !== 20'h00005 || seg_a !== {S0, S0, S0, S0, S5}) begin tests_failed++; $display("FAIL hold_release_display: got %h/%h need 00005/%h", bcd_a, seg_a, {S0, S0, S0, S0, S5}); end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        // next capture edge is 83 cycles after the valid; SHIFT spans the following 16
        repeat (90) @(posedge clk);
        @(negedge clk);
        rst_a = 1; half_a = 0; sig_a = 0; cnt_a = 0;
        @(posedge clk); #1;
        tests_run++;
        if (num_a !== 16'd0 || bcd_a !== 20'h0 || seg_a !== 35'h0 || ovf_a !== 1'b0 || val_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL midshift_reset: got num=%0d bcd=%h seg=%h ovf=%b val=%b need all 0", num_a, bcd_a, seg_a, ovf_a, val_a);
        end
        @(negedge clk);
        rst_a = 0; half_a = 10;
        wait_valid(0, 300, n);
        tests_run++;
        if (n != 117) begin tests_failed++; $display("FAIL midshift_latency: got %0d cycles need 117", n); end
        tests_run++;
        if (num_a !== 16'd5 || bcd_a !== 20'h00005 || ovf_a !== 1'b0) begin tests_failed++; $display("FAIL midshift_count: got %0d/%h ovf=%b need 5/00005 ovf=0", num_a, bcd_a, ovf_a); end
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clk);
        rst_b = 0; en_b = 1; half_b = 1;
        wait_valid(1, 200, n);
        tests_run++;
        if (n != 69) begin tests_failed++; $display("FAIL sat_latency: got %0d cycles need 69", n); end
        tests_run++;
        if (num_b !== 4'd15 || ovf_b !== 1'b1) begin tests_failed++; $display("FAIL sat_number: got %0d ovf=%b need 15 ovf=1", num_b, ovf_b); end
        tests_run++;
        if (bcd_b !== 20'h00015 || seg_b !== {S0, S0, S0, S1, S5}) begin tests_failed++; $display("FAIL sat_display: got %h/%h need 00015/%h", bcd_b, seg_b, {S0, S0, S0, S1, S5}); end
        @(negedge clk);
        half_b = 8;
        wait_valid(1, 200, n);
        wait_valid(1, 200, n);
        tests_run++;
        if (n != 64) begin tests_failed++; $display("FAIL sat_period: got %0d cycles need 64", n); end
        tests_run++;
        if (num_b !== 4'd4 || ovf_b !== 1'b0) begin tests_failed++; $display("FAIL sat_recover: got %0d ovf=%b need 4 ovf=0", num_b, ovf_b); end
        tests_run++;
        if (bcd_b !== 20'h00004 || seg_b !== {S0, S0, S0, S0, S4}) begin tests_failed++; $display("FAIL sat_recover_display: got %h/%h need 00004/%h", bcd_b, seg_b, {S0, S0, S0, S0, S4}); end
    endtask

    task automatic test_decimal_range();
        int n;
        @(negedge clk);
        rst_c = 0; en_c = 1; half_c = 5;
        wait_valid(2, 300, n);
        tests_run++;
        if (num_c !== 8'd10 || ovf_c !== 1'b1) begin tests_failed++; $display("FAIL decimal_over: got %0d ovf=%b need 10 ovf=1", num_c, ovf_c); end
        tests_run++;
        if (bcd_c !== 4'd0 || seg_c !== S0) begin tests_failed++; $display("FAIL decimal_low_digit: got %h/%h need 0/%h", bcd_c, seg_c, S0); end
        @(negedge clk);
        half_c = 10;
        wait_valid(2, 200, n);
        wait_valid(2, 200, n);
        tests_run++;
        if (num_c !== 8'd5 || ovf_c !== 1'b0 || bcd_c !== 4'd5 || seg_c !== S5) begin
            tests_failed++;
            $display("FAIL decimal_in_range: got %0d ovf=%b bcd=%h seg=%h need 5 0 5 %h", num_c, ovf_c, bcd_c, seg_c, S5);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_enable();
        test_hold();
        test_reset_mid_shift();
        test_saturation();
        test_decimal_range();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
